// File: rtl/laser_sched.sv
// Two-circle placement scheduler: loads a point pattern, then alternates raster
// sweeps of C1 and C2 against an external coverage evaluator until the best count settles.
module laser_sched #(
    parameter int NPTS     = 40,
    parameter int MAX_PASS = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    output logic       LD_VALID,
    output logic [5:0] LD_IDX,
    output logic       EV_REQ,
    output logic [3:0] EV_CX,
    output logic [3:0] EV_CY,
    output logic [3:0] EV_OX,
    output logic [3:0] EV_OY,
    input  logic       EV_ACK,
    input  logic [5:0] EV_CNT,
    output logic [3:0] C1X,
    output logic [3:0] C1Y,
    output logic [3:0] C2X,
    output logic [3:0] C2Y,
    output logic       DONE
);

    localparam int              PW        = $clog2(MAX_PASS + 1);
    localparam logic [5:0]      NPTS_W    = 6'(NPTS);
    localparam logic [5:0]      LAST_IDX  = 6'(NPTS - 1);
    localparam logic [PW-1:0]   LAST_PASS = PW'(MAX_PASS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN1,
        SCAN2,
        CHECK,
        FIN
    } state_t;

    state_t        state;
    logic [5:0]    ld_cnt;
    logic [7:0]    cand;
    logic [5:0]    best;
    logic [5:0]    prev_best;
    logic [PW-1:0] pass;
    logic [5:0]    cnt_clamped;
    logic          in_scan;
    logic          unused_xy;

    // Point data goes straight to the evaluator; this block only sequences it.
    assign unused_xy = ^{X, Y};

    assign LD_VALID = (state == LOAD);
    assign LD_IDX   = LD_VALID ? ld_cnt : '0;
    assign in_scan  = (state == SCAN1) || (state == SCAN2);

    always_comb begin
        cnt_clamped = EV_CNT;
        if (EV_CNT > NPTS_W) begin
            cnt_clamped = NPTS_W;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            ld_cnt    <= '0;
            cand      <= '0;
            best      <= '0;
            prev_best <= '0;
            pass      <= '0;
            EV_REQ    <= 1'b0;
            EV_CX     <= '0;
            EV_CY     <= '0;
            EV_OX     <= '0;
            EV_OY     <= '0;
            C1X       <= '0;
            C1Y       <= '0;
            C2X       <= '0;
            C2Y       <= '0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    ld_cnt <= '0;
                    state  <= LOAD;
                end

                LOAD: begin
                    if (ld_cnt == LAST_IDX) begin
                        ld_cnt    <= '0;
                        cand      <= '0;
                        best      <= '0;
                        prev_best <= '0;
                        pass      <= '0;
                        C1X       <= '0;
                        C1Y       <= '0;
                        C2X       <= '0;
                        C2Y       <= '0;
                        EV_REQ    <= 1'b0;
                        state     <= SCAN1;
                    end else begin
                        ld_cnt <= ld_cnt + 6'd1;
                    end
                end

                SCAN1, SCAN2: begin
                    if (!EV_REQ) begin
                        // The cycle with the request low doubles as the bus set-up cycle.
                        EV_REQ <= 1'b1;
                        EV_CX  <= cand[3:0];
                        EV_CY  <= cand[7:4];
                        EV_OX  <= (state == SCAN1) ? C2X : C1X;
                        EV_OY  <= (state == SCAN1) ? C2Y : C1Y;
                    end else if (EV_ACK) begin
                        EV_REQ <= 1'b0;
                        cand   <= cand + 8'd1;
                        if (cnt_clamped > best) begin
                            best <= cnt_clamped;
                            if (state == SCAN1) begin
                                C1X <= EV_CX;
                                C1Y <= EV_CY;
                            end else begin
                                C2X <= EV_CX;
                                C2Y <= EV_CY;
                            end
                        end
                        if (cand == 8'hFF) begin
                            state <= (state == SCAN1) ? SCAN2 : CHECK;
                        end
                    end
                end

                CHECK: begin
                    pass <= pass + PW'(1);
                    if ((best == prev_best) || (pass == LAST_PASS)) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        prev_best <= best;
                        state     <= SCAN1;
                    end
                end

                FIN: begin
                    state <= LOAD;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
            if (!in_scan && (state != LOAD)) begin
                EV_REQ <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laser_sched.sv
// Bench for laser_sched: Chebyshev-radius evaluator model, protocol monitor and a
// coordinate-descent reference computed directly from the scheduling rules.
module tb_laser_sched;

    localparam int NPTS = 40;
    localparam int RAD  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rst2 = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;

    logic       ld_valid, ev_req, ev_ack, done;
    logic [5:0] ld_idx, ev_cnt;
    logic [3:0] ev_cx, ev_cy, ev_ox, ev_oy, c1x, c1y, c2x, c2y;

    logic       ld_valid_b, ev_req_b, ev_ack_b, done_b;
    logic [5:0] ld_idx_b, ev_cnt_b;
    logic [3:0] ev_cx_b, ev_cy_b, ev_ox_b, ev_oy_b, c1x_b, c1y_b, c2x_b, c2y_b;

    always #5 clk = ~clk;

    laser_sched #(.NPTS(NPTS), .MAX_PASS(4)) dut (
        .CLK(clk), .RST(rst), .X(x), .Y(y),
        .LD_VALID(ld_valid), .LD_IDX(ld_idx),
        .EV_REQ(ev_req), .EV_CX(ev_cx), .EV_CY(ev_cy), .EV_OX(ev_ox), .EV_OY(ev_oy),
        .EV_ACK(ev_ack), .EV_CNT(ev_cnt),
        .C1X(c1x), .C1Y(c1y), .C2X(c2x), .C2Y(c2y), .DONE(done)
    );

    laser_sched #(.NPTS(NPTS), .MAX_PASS(1)) dut_one (
        .CLK(clk), .RST(rst2), .X(x), .Y(y),
        .LD_VALID(ld_valid_b), .LD_IDX(ld_idx_b),
        .EV_REQ(ev_req_b), .EV_CX(ev_cx_b), .EV_CY(ev_cy_b), .EV_OX(ev_ox_b), .EV_OY(ev_oy_b),
        .EV_ACK(ev_ack_b), .EV_CNT(ev_cnt_b),
        .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b), .DONE(done_b)
    );

    int         pat_x[NPTS];
    int         pat_y[NPTS];
    logic [3:0] cap_x[64];
    logic [3:0] cap_y[64];
    bit         ack_mode = 1'b0;
    bit         glitch_on = 1'b0;
    int         glitch_x = 0;
    int         glitch_y = 0;
    int         checks = 0;
    int         errors = 0;
    int         hold_viol = 0, gap_viol = 0, excl_viol = 0, done_viol = 0, cand_viol = 0;
    int         req_num = 0;
    logic       ack_q = 1'b0, stray_q = 1'b0;
    int         wait_cnt = 0;

    function automatic bit near(input int px, input int py, input int cx, input int cy);
        return (px - cx <= RAD) && (cx - px <= RAD) && (py - cy <= RAD) && (cy - py <= RAD);
    endfunction

    // Evaluator coverage; a glitch candidate reports an out-of-range count.
    function automatic int cover_cnt(input bit use_pat, input int cx, input int cy,
                                     input int ox, input int oy);
        int n = 0;
        for (int i = 0; i < NPTS; i++) begin
            int px = use_pat ? pat_x[i] : int'(cap_x[i]);
            int py = use_pat ? pat_y[i] : int'(cap_y[i]);
            if (near(px, py, cx, cy) || near(px, py, ox, oy)) n++;
        end
        if (glitch_on && cx == glitch_x && cy == glitch_y) n = 63;
        return n;
    endfunction

    always @(posedge clk) begin
        if (ld_valid) begin
            cap_x[ld_idx] <= x;
            cap_y[ld_idx] <= y;
        end
        stray_q <= ($urandom_range(0, 2) == 0);
        if (!rst) begin
            ack_q    <= 1'b0;
            wait_cnt <= 0;
        end else if (ack_q) begin
            ack_q    <= 1'b0;
            wait_cnt <= 0;
        end else if (ack_mode && ev_req) begin
            if (wait_cnt == 4) ack_q <= 1'b1;
            wait_cnt <= wait_cnt + 1;
        end
    end

    always_comb begin
        ev_ack   = ack_mode ? (ack_q | (stray_q & ~ev_req)) : ev_req;
        ev_cnt   = 6'(cover_cnt(1'b0, int'(ev_cx), int'(ev_cy), int'(ev_ox), int'(ev_oy)));
        ev_ack_b = ev_req_b;
        ev_cnt_b = 6'(cover_cnt(1'b0, int'(ev_cx_b), int'(ev_cy_b), int'(ev_ox_b), int'(ev_oy_b)));
    end

    logic        p_req = 1'b0, p_ack = 1'b0, p_done = 1'b0;
    logic [15:0] p_bus = '0;
    logic [7:0]  exp_cand = '0;

    always @(negedge clk) begin
        if (!rst) begin
            p_req    <= 1'b0;
            p_ack    <= 1'b0;
            p_done   <= 1'b0;
            exp_cand <= '0;
            req_num  <= 0;
        end else begin
            if (p_req && !p_ack && !(ev_req && {ev_cx, ev_cy, ev_ox, ev_oy} == p_bus))
                hold_viol <= hold_viol + 1;
            if (p_req && p_ack && ev_req) gap_viol <= gap_viol + 1;
            if (ev_req && (ld_valid || done)) excl_viol <= excl_viol + 1;
            if (done && p_done) done_viol <= done_viol + 1;
            if (ld_valid) begin
                exp_cand <= '0;
                req_num  <= 0;
            end else if (ev_req && !p_req) begin
                if ({ev_cy, ev_cx} != exp_cand) cand_viol <= cand_viol + 1;
                exp_cand <= exp_cand + 8'd1;
                req_num  <= req_num + 1;
            end
            p_req  <= ev_req;
            p_ack  <= ev_ack;
            p_done <= done;
            p_bus  <= {ev_cx, ev_cy, ev_ox, ev_oy};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input int maxp, output logic [15:0] centers, output int npass);
        int best = 0, prev = 0, v = 0;
        int r1x = 0, r1y = 0, r2x = 0, r2y = 0;
        bit stop = 1'b0;
        npass = 0;
        while (!stop) begin
            for (int cy = 0; cy < 16; cy++)
                for (int cx = 0; cx < 16; cx++) begin
                    v = cover_cnt(1'b1, cx, cy, r2x, r2y);
                    if (v > NPTS) v = NPTS;
                    if (v > best) begin best = v; r1x = cx; r1y = cy; end
                end
            for (int cy = 0; cy < 16; cy++)
                for (int cx = 0; cx < 16; cx++) begin
                    v = cover_cnt(1'b1, cx, cy, r1x, r1y);
                    if (v > NPTS) v = NPTS;
                    if (v > best) begin best = v; r2x = cx; r2y = cy; end
                end
            npass++;
            stop = (best == prev) || (npass == maxp);
            prev = best;
        end
        centers = {4'(r1x), 4'(r1y), 4'(r2x), 4'(r2y)};
    endtask

    task automatic set_const(input int px, input int py);
        for (int i = 0; i < NPTS; i++) begin pat_x[i] = px; pat_y[i] = py; end
    endtask

    task automatic set_random();
        for (int i = 0; i < NPTS; i++) begin
            pat_x[i] = $urandom_range(0, 15);
            pat_y[i] = $urandom_range(0, 15);
        end
    endtask

    task automatic load_pattern(input string tag, output int wait_cyc);
        int t = 0;
        int nbad = 0;
        while (ld_valid !== 1'b1 && t < 16) begin @(negedge clk); t++; end
        wait_cyc = t;
        chk({tag, "_load_start"}, ld_valid, 1);
        for (int k = 0; k < NPTS; k++) begin
            if (ld_valid !== 1'b1 || ld_idx !== 6'(k)) nbad++;
            x = 4'(pat_x[k]);
            y = 4'(pat_y[k]);
            @(negedge clk);
        end
        chk({tag, "_ld_idx_seq"}, nbad, 0);
        chk({tag, "_ld_valid_len"}, ld_valid, 0);
    endtask

    task automatic run_check(input string tag, input int per, output int wait_cyc);
        logic [15:0] exp_c;
        int np, cyc, lim;
        ref_model(4, exp_c, np);
        load_pattern(tag, wait_cyc);
        chk({tag, "_gap0"}, ev_req, 0);
        @(negedge clk);
        chk({tag, "_first_req"}, {ev_req, ev_cx, ev_cy, ev_ox, ev_oy}, {1'b1, 16'h0000});
        cyc = 41;
        lim = 40 + 4 * (512 * per + 1) + 10;
        while (done !== 1'b1 && cyc < lim) begin @(negedge clk); cyc++; end
        chk({tag, "_done_cycle"}, cyc, 40 + np * (512 * per + 1));
        chk({tag, "_centers"}, {c1x, c1y, c2x, c2y}, exp_c);
        @(negedge clk);
        chk({tag, "_centers_hold"}, {c1x, c1y, c2x, c2y}, exp_c);
        chk({tag, "_done_pulse"}, done, 0);
        #1;
        chk({tag, "_protocol"}, {hold_viol[7:0], gap_viol[7:0], excl_viol[7:0],
                                 done_viol[7:0], cand_viol[7:0]}, 0);
    endtask

    initial begin
        int t;
        int tmo;
        logic [15:0] exp1, exp4;
        int np1, np4, d1, d2, cyc;
        logic [15:0] got1, got2;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {ld_valid, ld_idx, ev_req, ev_cx, ev_cy, ev_ox, ev_oy,
                              c1x, c1y, c2x, c2y, done}, 0);
        rst = 1'b1;
        chk("idle_no_load", ld_valid, 0);

        set_const(3, 3);
        run_check("conv", 2, t);
        chk("conv_idle_one_cycle", t, 1);
        chk("conv_spec_centers", {c1x, c1y, c2x, c2y}, 16'h0000);

        for (int i = 0; i < NPTS; i++) begin
            pat_x[i] = (i < 20) ? 2 : 12;
            pat_y[i] = (i < 20) ? 2 : 12;
        end
        run_check("clusters", 2, t);
        chk("clusters_back_to_back", t, 0);

        set_random();
        run_check("rand_zero", 2, t);

        ack_mode = 1'b1;
        run_check("rand_delay", 7, t);
        ack_mode = 1'b0;

        set_const(3, 3);
        glitch_on = 1'b1;
        glitch_x  = 5;
        glitch_y  = 5;
        run_check("clamp", 2, t);
        glitch_on = 1'b0;

        set_random();
        load_pattern("midrst", t);
        tmo = 0;
        while (req_num < 357 && tmo < 2000) begin @(negedge clk); tmo++; end
        chk("midrst_reached_scan2", req_num >= 357, 1);
        rst = 1'b0;
        #1;
        chk("midrst_outputs_zero", {ld_valid, ld_idx, ev_req, ev_cx, ev_cy, ev_ox, ev_oy,
                                    c1x, c1y, c2x, c2y, done}, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_idle", ld_valid, 0);
        set_random();
        run_check("midrst_reload", 2, t);
        chk("midrst_reload_wait", t, 1);

        rst  = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        rst2 = 1'b1;
        set_random();
        ref_model(1, exp1, np1);
        ref_model(4, exp4, np4);
        load_pattern("maxpass", t);
        cyc = 40;
        d1 = -1;
        d2 = -1;
        got1 = '0;
        got2 = '0;
        while ((d1 < 0 || d2 < 0) && cyc < 40 + 4 * 1025 + 10) begin
            if (done === 1'b1 && d1 < 0) begin d1 = cyc; got1 = {c1x, c1y, c2x, c2y}; end
            if (done_b === 1'b1 && d2 < 0) begin d2 = cyc; got2 = {c1x_b, c1y_b, c2x_b, c2y_b}; end
            @(negedge clk);
            cyc++;
        end
        chk("maxpass1_done_cycle", d2, 40 + 1025);
        chk("maxpass1_centers", got2, exp1);
        chk("maxpass4_done_cycle", d1, 40 + np4 * 1025);
        chk("maxpass4_centers", got1, exp4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
